// File: rtl/stroke_render.sv
// Rasterises stroke points as square gray brushes into canvas pixel writes.
// Ports: pt_* point stream in (valid/ready), px_* pixel writes out, stroke_done pulse.
module stroke_render #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = 8,
  parameter int DW    = 8,
  parameter int MAX_R = 7,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pt_valid,
  output logic          pt_ready,
  input  logic [CW-1:0] pt_x,
  input  logic [CW-1:0] pt_y,
  input  logic [DW-1:0] pt_color,
  input  logic [3:0]    pt_radius,
  input  logic          pt_last,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [AW-1:0] px_addr,
  output logic [DW-1:0] px_data,
  output logic          stroke_done
);

  typedef enum logic {IDLE, RENDER} state_t;

  localparam logic signed [CW+1:0] WL = (CW+2)'(IMG_W);
  localparam logic signed [CW+1:0] HL = (CW+2)'(IMG_H);

  state_t state, state_n;

  logic [CW-1:0] x_q, y_q;
  logic [DW-1:0] color_q;
  logic          last_q;
  logic [3:0]    r_q;
  logic signed [CW+1:0] dx_q, dy_q;

  logic [3:0]           rc;
  logic signed [CW+1:0] rs, cx, cy;
  logic                 in_b, adv, at_end, acc;

  assign rc = (pt_radius > 4'(MAX_R)) ? 4'(MAX_R) : pt_radius;
  assign rs = signed'((CW+2)'(r_q));

  // Widened signed candidate so edges near 0 or 255 never wrap.
  assign cx = signed'({2'b00, x_q}) + dx_q;
  assign cy = signed'({2'b00, y_q}) + dy_q;

  assign in_b = (state == RENDER)
             && !cx[CW+1] && (cx < WL)
             && !cy[CW+1] && (cy < HL);

  assign pt_ready = (state == IDLE);
  assign acc      = pt_valid && pt_ready;

  assign px_valid = in_b;
  assign px_addr  = in_b ? (AW'(cy) * AW'(IMG_W) + AW'(cx)) : '0;
  assign px_data  = color_q;

  assign adv    = !px_valid || px_ready;
  assign at_end = (dx_q == rs) && (dy_q == rs);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (pt_valid) state_n = RENDER;
      RENDER: if (adv && at_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      color_q     <= '0;
      last_q      <= 1'b0;
      r_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      stroke_done <= 1'b0;
    end else begin
      state       <= state_n;
      stroke_done <= (state == RENDER) && adv && at_end && last_q;
      if (acc) begin
        x_q     <= pt_x;
        y_q     <= pt_y;
        color_q <= pt_color;
        last_q  <= pt_last;
        r_q     <= rc;
        dx_q    <= -signed'((CW+2)'(rc));
        dy_q    <= -signed'((CW+2)'(rc));
      end else if (state == RENDER && adv) begin
        if (dx_q == rs) begin
          dx_q <= -rs;
          dy_q <= dy_q + 1'b1;
        end else begin
          dx_q <= dx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/stroke_render.md
Name: stroke_render

Overview:
- Consumes the stroke point stream produced by the stroke generator and rasterises each point as a square brush of 8-bit gray colour.
- Emits one canvas pixel write per in-bounds brush pixel to the frame-buffer writer.
- Sits between stroke generation and canvas memory.
- Valid/ready on both sides; one stroke is a sequence of points ending with a point that has the last flag set.

Parameters:
IMG_W, 64, canvas width in pixels
IMG_H, 64, canvas height in pixels
CW, 8, coordinate width (unsigned)
DW, 8, pixel/colour width
MAX_R, 7, largest brush radius; larger requests are clamped
AW, 12, pixel address width (≥ clog2(IMG_W*IMG_H))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
pt_valid  in  1  stroke point available
pt_ready  out  1  block can accept a point
pt_x  in  CW  point centre column
pt_y  in  CW  point centre row
pt_color  in  DW  brush colour
pt_radius  in  4  brush radius
pt_last  in  1  final point of the stroke
px_valid  out  1  pixel write valid
px_ready  in  1  frame buffer accepts write
px_addr  out  AW  py*IMG_W+px
px_data  out  DW  colour
stroke_done  out  1  one-cycle pulse after the last point of a stroke finishes

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-low.
- Reset values:
  - state IDLE
  - pt_ready=1, px_valid=0, px_addr=0, px_data=0, stroke_done=0
  - all latched fields and counters 0
- Reset asserted mid-render aborts the point immediately. No further writes are issued. After release the block is IDLE with pt_ready=1.
- States are IDLE and RENDER.
- pt_ready = (state==IDLE).
- Accept on pt_valid && pt_ready:
  - Latch x, y, color and last.
  - Latch r = min(pt_radius, MAX_R).
  - Set dy=-r, dx=-r (signed, CW+2 bits).
  - Go to RENDER.
- RENDER, each cycle presents one candidate pixel:
  - Candidate: px=x+dx, py=y+dy, computed signed with CW+2 bits so there is no wrap.
  - in_bounds = 0≤px<IMG_W && 0≤py<IMG_H.
  - px_valid = in_bounds.
  - px_addr = py*IMG_W+px, truncated to AW; valid only when in_bounds.
  - px_data = latched color.
- Advance condition: advance = !px_valid || px_ready.
  - Out-of-bounds candidates consume exactly one cycle with px_valid=0.
  - While px_valid && !px_ready, px_valid, px_addr and px_data hold stable.
- Scan order is raster: dx from -r to +r inner, dy from -r to +r outer.
  - Total candidate cycles ≥ (2r+1)^2.
  - r=0 gives a single candidate.
- On advance at dx=r, dy=r: go to IDLE. If last, stroke_done=1 for exactly the next cycle, which is the same cycle pt_ready returns high.
- Latency: a point accepted at edge T presents its first candidate in cycle T+1. With px_ready held high, pt_ready returns at T+1+(2r+1)^2.
- No overlap between points and no point buffering. pt_valid while in RENDER is ignored (back-pressured).
- Coordinates ≥ IMG_W/IMG_H are legal; their pixels are clipped by the bounds check.
- Points with pt_last=0 never pulse stroke_done.

Test Plan:
- Point (10,20), r=0, color 0x5A, last=1, px_ready=1 → one write addr 1290 data 0x5A in cycle T+1; stroke_done and pt_ready high in T+2.
- Point (10,10), r=1, color 0x80 → 9 writes on consecutive cycles, addrs 585,586,587,649,650,651,713,714,715; no stroke_done when last=0.
- Corner point (0,0), r=2 → 25 candidate cycles, exactly 9 valid writes with addrs 0,1,2,64,65,66,128,129,130; invalid cycles carry px_valid=0.
- Backpressure: point (5,5), r=1 with px_ready toggling 1,0,0,1,… → outputs stable while stalled; exactly 9 unique writes in raster order, none lost or duplicated.
- pt_radius=12, point (32,32), last=1 → clamped to 7: 225 writes, first addr 25*64+25=1625, last addr 39*64+39=2535; stroke_done is a single-cycle pulse.
- Assert rst low mid-render of an r=3 point → px_valid=0 and pt_ready=1 immediately; no writes after release until a new point is accepted.
